// File: rtl/alu_pkg.sv
// Shared constants and types for the sliced 74181-style ALU.
package alu_pkg;

  localparam int unsigned SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  // Commonly used 74181 function selects
  localparam logic [3:0] S_ADD   = 4'b1001;  // M=0: A plus B
  localparam logic [3:0] S_SUB   = 4'b0110;  // M=0: A minus B minus 1 (plus carry)
  localparam logic [3:0] S_XOR_L = 4'b0110;  // M=1: A xor B
  localparam logic [3:0] S_A     = 4'b0000;

endpackage

// File: rtl/alu181_slice.sv
// Combinational 4-bit 74181 function, active-high data, active-low carries.
module alu181_slice
  import alu_pkg::*;
(
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic [3:0]         s,
  input  logic               M,
  input  logic               Ci_inverse,
  output logic [SLICE_W-1:0] Y,
  output logic               Co_inverse
);

  logic [SLICE_W-1:0] p;
  logic [SLICE_W-1:0] g;
  logic [SLICE_W:0]   c;

  // Per-bit propagate/generate terms, ripple carry, and result select by mode.
  // The arithmetic result is p + g + carry; logic mode is the carry-free
  // complement of p xor g.
  always_comb begin
    p    = a | (b & {SLICE_W{s[0]}}) | (~b & {SLICE_W{s[1]}});
    g    = (a & ~b & {SLICE_W{s[2]}}) | (a & b & {SLICE_W{s[3]}});
    c    = '0;
    c[0] = ~Ci_inverse;
    for (int unsigned i = 0; i < SLICE_W; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    if (M) begin
      Y          = ~(p ^ g);
      Co_inverse = 1'b1;
    end else begin
      Y          = p ^ g ^ c[SLICE_W-1:0];
      Co_inverse = ~c[SLICE_W];
    end
  end

endmodule

// File: rtl/alu_seq_slicer.sv
// WIDTH-bit 74181-style ALU evaluated one 4-bit slice per clock, LSB first,
// with a registered active-low carry between slices and valid/ready on both sides.
module alu_seq_slicer
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned NSLICE = WIDTH / SLICE_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [3:0]       s_in,
  input  logic             M_in,
  input  logic             Ci_inverse_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Y_out,
  output logic             Co_inverse_out,
  output logic             AequalsB_out,
  output logic             busy_out
);

  localparam int unsigned   CW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

  state_t             state;
  state_t             state_nxt;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   y_q;
  logic [WIDTH-1:0]   y_nxt;
  logic [3:0]         s_q;
  logic               m_q;
  logic               carry_q;
  logic               co_q;
  logic               aeqb_q;
  logic [SLICE_W-1:0] a_sl;
  logic [SLICE_W-1:0] b_sl;
  logic [SLICE_W-1:0] y_sl;
  logic               co_sl;
  logic               accept;
  logic               last;

  assign accept = in_valid & in_ready;
  assign last   = (cnt == LAST);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (last) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = in_valid ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake and status outputs decoded from state
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy_out  = 1'b0;
    unique case (state)
      IDLE:    in_ready = 1'b1;
      RUN:     busy_out = 1'b1;
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
      end
      default: in_ready = 1'b0;
    endcase
  end

  // Select the operand slice addressed by the counter
  always_comb begin
    a_sl = '0;
    b_sl = '0;
    for (int unsigned k = 0; k < NSLICE; k++) begin
      if (cnt == CW'(k)) begin
        a_sl = a_q[k*SLICE_W +: SLICE_W];
        b_sl = b_q[k*SLICE_W +: SLICE_W];
      end
    end
  end

  // Merge the current slice result into the result word
  always_comb begin
    y_nxt = y_q;
    for (int unsigned k = 0; k < NSLICE; k++) begin
      if (cnt == CW'(k)) y_nxt[k*SLICE_W +: SLICE_W] = y_sl;
    end
  end

  alu181_slice u_slice (
    .a          (a_sl),
    .b          (b_sl),
    .s          (s_q),
    .M          (m_q),
    .Ci_inverse (carry_q),
    .Y          (y_sl),
    .Co_inverse (co_sl)
  );

  // Operand capture on accept, slice-by-slice accumulation while running.
  // Carry-out and A=B flag are committed only with the final slice so they
  // never reflect a partial result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      m_q     <= 1'b0;
      carry_q <= 1'b1;
      cnt     <= '0;
      y_q     <= '0;
      co_q    <= 1'b1;
      aeqb_q  <= 1'b0;
    end else if (accept) begin
      a_q     <= a_in;
      b_q     <= b_in;
      s_q     <= s_in;
      m_q     <= M_in;
      carry_q <= Ci_inverse_in;
      cnt     <= '0;
    end else if (state == RUN) begin
      y_q     <= y_nxt;
      carry_q <= co_sl;
      if (last) begin
        cnt    <= '0;
        co_q   <= co_sl;
        aeqb_q <= &y_nxt;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign Y_out          = y_q;
  assign Co_inverse_out = co_q;
  assign AequalsB_out   = aeqb_q;

endmodule

// File: tb/tb_alu_seq_slicer.sv
// Scoreboard bench for alu_seq_slicer: expected results come from a
// full-width 74181 function-table model and are queued at issue time.
module tb_alu_seq_slicer;
  import alu_pkg::*;

  localparam int unsigned W = 16;

  typedef struct packed {
    logic [W-1:0] y;
    logic         co;
    logic         aeqb;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic [3:0]   s_in;
  logic         M_in;
  logic         Ci_inverse_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] Y_out;
  logic         Co_inverse_out;
  logic         AequalsB_out;
  logic         busy_out;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  alu_seq_slicer #(.WIDTH(W)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .a_in           (a_in),
    .b_in           (b_in),
    .s_in           (s_in),
    .M_in           (M_in),
    .Ci_inverse_in  (Ci_inverse_in),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .Y_out          (Y_out),
    .Co_inverse_out (Co_inverse_out),
    .AequalsB_out   (AequalsB_out),
    .busy_out       (busy_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datasheet function table: logic column directly, arithmetic column as
  // a sum of two full-width operands plus the (active-high) carry-in.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [3:0] s, input logic m, input logic ci_n);
    exp_t         e;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic [W-1:0] f;
    logic [W:0]   sum;
    if (m) begin
      case (s)
        4'h0: f = ~a;
        4'h1: f = ~(a | b);
        4'h2: f = ~a & b;
        4'h3: f = '0;
        4'h4: f = ~(a & b);
        4'h5: f = ~b;
        4'h6: f = a ^ b;
        4'h7: f = a & ~b;
        4'h8: f = ~a | b;
        4'h9: f = ~(a ^ b);
        4'hA: f = b;
        4'hB: f = a & b;
        4'hC: f = '1;
        4'hD: f = a | ~b;
        4'hE: f = a | b;
        default: f = a;
      endcase
      e.y  = f;
      e.co = 1'b1;
    end else begin
      case (s)
        4'h0: begin x = a;      y = '0;     end
        4'h1: begin x = a | b;  y = '0;     end
        4'h2: begin x = a | ~b; y = '0;     end
        4'h3: begin x = '1;     y = '0;     end
        4'h4: begin x = a;      y = a & ~b; end
        4'h5: begin x = a | b;  y = a & ~b; end
        4'h6: begin x = a;      y = ~b;     end
        4'h7: begin x = a & ~b; y = '1;     end
        4'h8: begin x = a;      y = a & b;  end
        4'h9: begin x = a;      y = b;      end
        4'hA: begin x = a | ~b; y = a & b;  end
        4'hB: begin x = a & b;  y = '1;     end
        4'hC: begin x = a;      y = a;      end
        4'hD: begin x = a | b;  y = a;      end
        4'hE: begin x = a | ~b; y = a;      end
        default: begin x = a;   y = '1;     end
      endcase
      sum  = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ~ci_n};
      e.y  = sum[W-1:0];
      e.co = ~sum[W];
    end
    e.aeqb = &e.y;
    return e;
  endfunction

  // Present one operation for a single edge (caller ensures in_ready) and queue its result.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [3:0] s, input logic m, input logic ci_n);
    a_in = a; b_in = b; s_in = s; M_in = m; Ci_inverse_in = ci_n;
    in_valid = 1'b1;
    sb.push_back(model(a, b, s, m, ci_n));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Wait (bounded) for out_valid; reports edges elapsed.
  task automatic wait_done(output int edges, output bit ok);
    edges = 0;
    ok    = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      edges++;
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic finish_op();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a_in = '0; b_in = '0; s_in = '0; M_in = 1'b0; Ci_inverse_in = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    n_cmp++;
    if ({out_valid, in_ready, busy_out, Y_out, Co_inverse_out, AequalsB_out} !==
        {1'b0, 1'b1, 1'b0, {W{1'b0}}, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL reset: got ov=%b ir=%b busy=%b Y=%h co=%b eq=%b want 0 1 0 0000 1 0",
               out_valid, in_ready, busy_out, Y_out, Co_inverse_out, AequalsB_out);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_add();
    exp_t e; int edges; bit ok;
    start_op(16'h00FF, 16'h0001, S_ADD, 1'b0, 1'b1);
    n_cmp++;
    if (busy_out !== 1'b1 || in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL add_busy: got busy=%b ir=%b want 1 0", busy_out, in_ready);
    end
    wait_done(edges, ok);
    e = sb.pop_front();
    n_cmp++;
    if (!ok || edges != 4) begin
      n_bad++;
      $display("FAIL add_latency: got %0d edges (valid=%b) want 4", edges, ok);
    end
    n_cmp++;
    if ({Y_out, Co_inverse_out, AequalsB_out} !== {e.y, e.co, e.aeqb}) begin
      n_bad++;
      $display("FAIL add_result: got Y=%h co=%b eq=%b want Y=%h co=%b eq=%b",
               Y_out, Co_inverse_out, AequalsB_out, e.y, e.co, e.aeqb);
    end
    finish_op();
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL add_release: got ov=%b ir=%b want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_ripple_and_sub();
    exp_t e; int edges; bit ok;
    logic [W-1:0] av[3];
    logic [W-1:0] bv[3];
    logic [3:0]   sv[3];
    logic         cv[3];
    av = '{16'hFFFF, 16'h1234, 16'h1234};
    bv = '{16'h0001, 16'h1234, 16'h1234};
    sv = '{S_ADD, S_SUB, S_SUB};
    cv = '{1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      start_op(av[i], bv[i], sv[i], 1'b0, cv[i]);
      wait_done(edges, ok);
      e = sb.pop_front();
      n_cmp++;
      if (!ok || {Y_out, Co_inverse_out, AequalsB_out} !== {e.y, e.co, e.aeqb}) begin
        n_bad++;
        $display("FAIL arith_%0d: got Y=%h co=%b eq=%b want Y=%h co=%b eq=%b",
                 i, Y_out, Co_inverse_out, AequalsB_out, e.y, e.co, e.aeqb);
      end
      finish_op();
    end
  endtask

  task automatic test_xor_midrun();
    exp_t e; int edges; bit ok;
    start_op(16'h0F0F, 16'h00FF, S_XOR_L, 1'b1, 1'b0);
    @(posedge clk); #1;
    a_in = 16'hA5A5; b_in = 16'h3C3C; s_in = S_ADD; M_in = 1'b0;
    wait_done(edges, ok);
    e = sb.pop_front();
    n_cmp++;
    if (!ok || {Y_out, Co_inverse_out, AequalsB_out} !== {e.y, e.co, e.aeqb}) begin
      n_bad++;
      $display("FAIL xor_midrun: got Y=%h co=%b eq=%b want Y=%h co=%b eq=%b",
               Y_out, Co_inverse_out, AequalsB_out, e.y, e.co, e.aeqb);
    end
    finish_op();
  endtask

  task automatic test_back_to_back();
    exp_t e; int edges; bit ok;
    start_op(16'h4321, 16'h1111, S_SUB, 1'b0, 1'b0);
    wait_done(edges, ok);
    e = sb.pop_front();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if ({out_valid, in_ready, Y_out, Co_inverse_out, AequalsB_out} !==
          {1'b1, 1'b0, e.y, e.co, e.aeqb}) begin
        n_bad++;
        $display("FAIL hold_%0d: got ov=%b ir=%b Y=%h co=%b eq=%b want 1 0 %h %b %b",
                 i, out_valid, in_ready, Y_out, Co_inverse_out, AequalsB_out, e.y, e.co, e.aeqb);
      end
    end
    a_in = 16'h7FFF; b_in = 16'h8001; s_in = S_ADD; M_in = 1'b0; Ci_inverse_in = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    sb.push_back(model(16'h7FFF, 16'h8001, S_ADD, 1'b0, 1'b0));
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_ready: got ir=%b want 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || busy_out !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_accept: got ov=%b busy=%b want 0 1", out_valid, busy_out);
    end
    wait_done(edges, ok);
    e = sb.pop_front();
    n_cmp++;
    if (!ok || edges != 4) begin
      n_bad++;
      $display("FAIL b2b_latency: got %0d edges (valid=%b) want 4", edges, ok);
    end
    n_cmp++;
    if ({Y_out, Co_inverse_out, AequalsB_out} !== {e.y, e.co, e.aeqb}) begin
      n_bad++;
      $display("FAIL b2b_result: got Y=%h co=%b eq=%b want Y=%h co=%b eq=%b",
               Y_out, Co_inverse_out, AequalsB_out, e.y, e.co, e.aeqb);
    end
    finish_op();
  endtask

  task automatic test_async_reset();
    exp_t e; int edges; bit ok;
    start_op(16'hFFFF, 16'hFFFF, S_ADD, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    #2 rst_n = 1'b0;
    #1;
    sb.delete();
    n_cmp++;
    if ({out_valid, in_ready, busy_out, Y_out, Co_inverse_out, AequalsB_out} !==
        {1'b0, 1'b1, 1'b0, {W{1'b0}}, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL midrun_reset: got ov=%b ir=%b busy=%b Y=%h co=%b eq=%b want 0 1 0 0000 1 0",
               out_valid, in_ready, busy_out, Y_out, Co_inverse_out, AequalsB_out);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    start_op(16'h0001, 16'h0001, S_ADD, 1'b0, 1'b1);
    wait_done(edges, ok);
    e = sb.pop_front();
    n_cmp++;
    if (!ok || {Y_out, Co_inverse_out, AequalsB_out} !== {e.y, e.co, e.aeqb}) begin
      n_bad++;
      $display("FAIL post_reset_add: got Y=%h co=%b eq=%b want Y=%h co=%b eq=%b",
               Y_out, Co_inverse_out, AequalsB_out, e.y, e.co, e.aeqb);
    end
    finish_op();
  endtask

  task automatic test_random();
    exp_t e; int edges; bit ok;
    for (int i = 0; i < 32; i++) begin
      start_op(W'($urandom), W'($urandom), 4'($urandom_range(0, 15)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      wait_done(edges, ok);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      e = sb.pop_front();
      n_cmp++;
      if (!ok || {Y_out, Co_inverse_out, AequalsB_out} !== {e.y, e.co, e.aeqb}) begin
        n_bad++;
        $display("FAIL random_%0d: got Y=%h co=%b eq=%b want Y=%h co=%b eq=%b",
                 i, Y_out, Co_inverse_out, AequalsB_out, e.y, e.co, e.aeqb);
      end
      finish_op();
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_ripple_and_sub();
    test_xor_midrun();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_seq_slicer.md
Name: alu_seq_slicer

Overview:
- Parametrised, multi-cycle successor to the 4-bit 74181-style ALU.
- Takes a WIDTH-bit operation and processes it one 4-bit slice per clock, least-significant slice first.
- The active-low carry ripples between slices through a register.
- Sits between an operand source and a result consumer, with valid/ready handshakes on both sides.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4.
- NSLICE, WIDTH/4, derived slice count; do not override.

Ports:
- clk  input  1  clock; rising edge active.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operation request.
- in_ready  output  1  block can accept an operation this cycle.
- a_in  input  WIDTH  operand A.
- b_in  input  WIDTH  operand B.
- s_in  input  4  74181 function select.
- M_in  input  1  mode: 1 = logic, 0 = arithmetic.
- Ci_inverse_in  input  1  active-low carry into slice 0.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes the result.
- Y_out  output  WIDTH  result.
- Co_inverse_out  output  1  active-low carry out of the top slice.
- AequalsB_out  output  1  1 when Y_out is all ones (74181 A=B semantics).
- busy_out  output  1  state is RUN.

Behaviour:
- Reset: clk is the only clock; rst_n is asynchronous and active-low. Reset forces state IDLE, slice counter 0, and Y_out = 0. It also drives Co_inverse_out = 1, AequalsB_out = 0, out_valid = 0, busy_out = 0 and in_ready = 1. Reset during RUN or DONE aborts the operation with no partial result visible.
- States:
  - IDLE: idle.
  - RUN: processing slices.
  - DONE: holding the result.
- Handshake:
  - in_ready = (IDLE) OR (DONE AND out_ready).
  - An operation is accepted on a rising edge with in_valid & in_ready.
  - On acceptance, a_in, b_in, s_in, M_in and Ci_inverse_in are latched, the carry register is loaded with Ci_inverse_in, the counter is cleared, and the state moves to RUN.
  - Inputs changing after acceptance have no effect.
- RUN, one edge per slice k = 0..NSLICE-1:
  - Apply alu181_slice to A[4k+3:4k], B[4k+3:4k], the latched s/M and the carry register.
  - Write the slice result into Y[4k+3:4k], load the carry register with the slice's Co_inverse, and increment the counter.
  - After slice NSLICE-1, move to DONE.
- Latency: out_valid rises NSLICE edges after the accepting edge. With WIDTH=4 that is 1 edge.
- DONE:
  - out_valid = 1; Y_out, Co_inverse_out and AequalsB_out are stable.
  - They are held indefinitely while out_ready = 0.
  - On out_ready: if in_valid is also high, the new operation is accepted on the same edge and the state goes directly to RUN (out_valid drops for one or more cycles). Otherwise the state returns to IDLE.
- Y_out is only defined while out_valid = 1; it keeps its last value otherwise.
- Logic mode (M_in = 1): the carry chain is ignored and Co_inverse_out = 1.
- Arithmetic mode: the full 74181 function set per slice; the carry propagates across all slices exactly as a WIDTH-bit 74181 cascade would.
- AequalsB_out = AND of all Y bits, registered with Y.
- in_valid while in RUN: ignored; in_ready is 0.
- Counter width is max(1, clog2(NSLICE)); it never wraps past NSLICE-1.

Decomposition:
- Package alu_pkg holds:
  - SLICE_W = 4.
  - State enum {IDLE, RUN, DONE}.
  - Function-select constants: S_ADD = 4'b1001, S_SUB = 4'b0110, S_XOR_L = 4'b0110 (with M=1), S_A = 4'b0000.
- Sub-module alu181_slice: a combinational 4-bit 74181 function with inputs a, b, s, M, Ci_inverse and outputs Y, Co_inverse. It is instantiated once and time-multiplexed by the slice counter.

Test Plan:
- WIDTH=16, ADD (s=1001, M=0, Ci_inverse=1), A=0x00FF, B=0x0001 -> Y=0x0100, Co_inverse=1, AequalsB=0; out_valid exactly 4 edges after accept.
- ADD, A=0xFFFF, B=0x0001, Ci_inverse=1 -> Y=0x0000, Co_inverse=0. Covers carry rippling through all 4 slices.
- SUB (s=0110, M=0), A=B=0x1234: with Ci_inverse=0 -> Y=0x0000; with Ci_inverse=1 -> Y=0xFFFF, AequalsB=1.
- Logic XOR (s=0110, M=1), A=0x0F0F, B=0x00FF -> Y=0x0FF0, Co_inverse=1. Change a_in mid-RUN -> result unchanged.
- Back-pressure and back-to-back:
  - Hold out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0.
  - Then assert out_ready together with in_valid -> the new operation is accepted on the same edge and its result appears 4 edges later.
- Assert rst_n=0 asynchronously in mid-RUN (after 2 slices) -> outputs return to reset values immediately. After release, a fresh ADD 0x0001+0x0001 -> Y=0x0002.
